// File: rtl/tt_capture_if.sv
// tt_capture_if: capture bus (start/vld/abcd/f toward tt_capture, busy/done/table_out/seen/match/err back)
interface tt_capture_if;
  logic        start;
  logic        vld;
  logic [3:0]  abcd;
  logic        f;
  logic        busy;
  logic        done;
  logic [15:0] table_out;
  logic [15:0] seen;
  logic        match;
  logic        err;
  modport slave (input start, vld, abcd, f, output busy, done, table_out, seen, match, err);
  modport master (output start, vld, abcd, f, input busy, done, table_out, seen, match, err);
endinterface

// File: rtl/tt_capture.sv
// tt_capture: sweeps 16 patterns, samples f SETTLE cycles after each vld into table_out/seen (ports clk, rst, bus.slave; macro TT_CAPTURE_DUP_EN flags duplicate captures in err)
module tt_capture #(
  parameter int unsigned SETTLE   = 2,
  parameter logic [15:0] EXPECTED = 16'h0000
) (
  input  logic          clk,
  input  logic          rst,
  tt_capture_if.slave   bus
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SETTLE, S_DONE} state_t;
  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d, cnt_q, cnt_d;
  logic [15:0] table_q, table_d, seen_q, seen_d, tbl_w, seen_w;
  logic        match_q, match_d, err_q, err_d, cap, dup;
`ifdef TT_CAPTURE_DUP_EN
  assign dup = seen_q[idx_q];
`else
  assign dup = 1'b0;
`endif
  assign cap = state_q == S_SETTLE && cnt_q == 4'd1;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    table_d = table_q;
    seen_d  = seen_q;
    match_d = match_q;
    err_d   = err_q;
    tbl_w   = table_q;
    tbl_w[idx_q] = bus.f;
    seen_w  = seen_q | (16'h1 << idx_q);
    if (bus.start) begin
      table_d = '0;
      seen_d  = '0;
      match_d = 1'b0;
      err_d   = 1'b0;
      state_d = S_WAIT;
    end else if (state_q == S_WAIT && bus.vld) begin
      idx_d   = bus.abcd;
      cnt_d   = 4'(SETTLE);
      state_d = S_SETTLE;
    end else if (state_q == S_SETTLE) begin
      cnt_d = cnt_q - 4'd1;
      err_d = err_q | bus.vld | (cap & dup);
      if (cap) begin
        table_d = tbl_w;
        seen_d  = seen_w;
        state_d = &seen_w ? S_DONE : S_WAIT;
        match_d = &seen_w ? tbl_w == EXPECTED : match_q;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      table_q <= '0;
      seen_q  <= '0;
      match_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      table_q <= table_d;
      seen_q  <= seen_d;
      match_q <= match_d;
      err_q   <= err_d;
    end
  end
  assign bus.busy      = state_q == S_WAIT || state_q == S_SETTLE;
  assign bus.done      = state_q == S_DONE;
  assign bus.table_out = table_q;
  assign bus.seen      = seen_q;
  assign bus.match     = match_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_tt_capture.sv
// tb_tt_capture: directed checks of tt_capture sweeps, overrun, duplicates, reset and abort
module tb_tt_capture;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   fails = 0;
  tt_capture_if bus ();
  tt_capture #(.SETTLE(2), .EXPECTED(16'h8000)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [3:0] a, input logic fv);
    @(negedge clk);
    bus.vld  = 1'b1;
    bus.abcd = a;
    bus.f    = fv;
    @(negedge clk);
    bus.vld = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  task automatic go();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  initial begin
    bus.start = 1'b0;
    bus.vld   = 1'b0;
    bus.abcd  = 4'd0;
    bus.f     = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 16'(bus.busy), 16'd0);
    chk("rst_done", 16'(bus.done), 16'd0);
    chk("rst_table", bus.table_out, 16'h0000);
    chk("rst_seen", bus.seen, 16'h0000);
    chk("rst_match_err", {14'd0, bus.match, bus.err}, 16'd0);
    send(4'd3, 1'b1);
    chk("idle_ignores_vld", {bus.seen[14:0], bus.busy}, 16'd0);
    go();
    chk("start_busy", 16'(bus.busy), 16'd1);
    for (int i = 0; i < 16; i++) send(4'(i), i == 15);
    chk("and_done", 16'(bus.done), 16'd1);
    chk("and_table", bus.table_out, 16'h8000);
    chk("and_match", 16'(bus.match), 16'd1);
    chk("and_err", 16'(bus.err), 16'd0);
    chk("and_busy", 16'(bus.busy), 16'd0);
    chk("and_seen", bus.seen, 16'hFFFF);
    go();
    chk("restart_clear", {bus.seen[14:0], bus.match}, 16'd0);
    for (int i = 0; i < 16; i++) send(4'(i), i == 5);
    chk("p5_table", bus.table_out, 16'h0020);
    chk("p5_match", 16'(bus.match), 16'd0);
    chk("p5_done", 16'(bus.done), 16'd1);
    go();
    for (int i = 0; i < 4; i++) send(4'(i), 1'b0);
    send(4'd3, 1'b1);
    chk("dup_not_done", 16'(bus.done), 16'd0);
    for (int i = 4; i < 16; i++) send(4'(i), 1'b0);
    chk("dup_table", bus.table_out, 16'h0008);
    chk("dup_done", 16'(bus.done), 16'd1);
`ifdef TT_CAPTURE_DUP_EN
    chk("dup_err", 16'(bus.err), 16'd1);
`else
    chk("dup_err", 16'(bus.err), 16'd0);
`endif
    go();
    @(negedge clk);
    bus.vld  = 1'b1;
    bus.abcd = 4'd2;
    bus.f    = 1'b1;
    @(negedge clk);
    bus.abcd = 4'd9;
    @(negedge clk);
    bus.vld = 1'b0;
    repeat (4) @(negedge clk);
    chk("ovr_err", 16'(bus.err), 16'd1);
    chk("ovr_seen", bus.seen, 16'h0004);
    chk("ovr_table", bus.table_out, 16'h0004);
    chk("ovr_busy", 16'(bus.busy), 16'd1);
    go();
    @(negedge clk);
    bus.vld  = 1'b1;
    bus.abcd = 4'd7;
    bus.f    = 1'b1;
    @(negedge clk);
    bus.vld = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstmid_table", bus.table_out, 16'h0000);
    chk("rstmid_seen", bus.seen, 16'h0000);
    chk("rstmid_flags", {12'd0, bus.busy, bus.done, bus.match, bus.err}, 16'd0);
    send(4'd4, 1'b1);
    chk("rstmid_idle", {bus.seen[14:0], bus.busy}, 16'd0);
    chk("rstmid_idle_tbl", bus.table_out, 16'h0000);
    go();
    for (int i = 0; i < 15; i++) send(4'(i), 1'b1);
    chk("abort_pre_seen", bus.seen, 16'h7FFF);
    @(negedge clk);
    bus.vld  = 1'b1;
    bus.abcd = 4'd15;
    bus.f    = 1'b1;
    @(negedge clk);
    bus.vld = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("abort_done", 16'(bus.done), 16'd0);
    chk("abort_seen", bus.seen, 16'h0000);
    chk("abort_busy", 16'(bus.busy), 16'd1);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/tt_capture.md
TT_CAPTURE -- requirements
Module: tt_capture

Interface
REQ-001 Parameter SETTLE, default 2: cycles from an accepted vld to sampling f; legal range 1..15.
REQ-002 Parameter EXPECTED, default 16'h0000: golden truth table, bit i = required f for pattern i.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle pulse; clears capture state and arms a new sweep.
REQ-006 vld  input  1  one-cycle strobe; abcd is the pattern now being applied to the DUT.
REQ-007 abcd  input  4  applied pattern, abcd[3]=A .. abcd[0]=D, index i = {A,B,C,D}.
REQ-008 f  input  1  DUT response under observation.
REQ-009 busy  output  1  high in WAIT and SETTLE states.
REQ-010 done  output  1  high in DONE state.
REQ-011 table_out  output  16  captured truth table, bit i = f sampled for pattern i.
REQ-012 seen  output  16  bit i set once pattern i has been captured.
REQ-013 match  output  1  valid while done; table_out == EXPECTED.
REQ-014 err  output  1  sticky: duplicate pattern or vld overrun since last start.

Function
REQ-015 FSM states SHALL be IDLE, WAIT, SETTLE, DONE, one-hot or binary.
REQ-016 IDLE: start -> clear table_out, seen, err, match; next state WAIT; vld ignored.
REQ-017 WAIT: vld at edge E0 -> latch abcd into 4-bit idx, load settle counter with SETTLE, next state SETTLE.
REQ-018 SETTLE: counter decrements each edge; at edge E0+SETTLE f SHALL be written to table_out[idx] and seen[idx] set.
REQ-019 On that edge, if seen becomes 16'hFFFF next state SHALL be DONE, else WAIT.
REQ-020 match SHALL be registered on the DONE-entry edge as (final table_out == EXPECTED), including the bit written on that edge.
REQ-021 vld received in SETTLE SHALL be ignored for capture and SHALL set err.
REQ-022 Capture of an index whose seen bit is already set SHALL overwrite table_out[idx] and set err (see REQ-029).
REQ-023 DONE: outputs hold; start -> same clear as REQ-016, next state WAIT.
REQ-024 start in WAIT or SETTLE SHALL abort the sweep: clear per REQ-016, next state WAIT; start beats a simultaneous vld or final capture.
REQ-025 Patterns SHALL be accepted in any order; sweep latency = 16 captures, minimum 16*(SETTLE+1) cycles.

Reset
REQ-026 rst SHALL asynchronously force state IDLE and busy=0, done=0, match=0, err=0, table_out=16'h0000, seen=16'h0000, settle counter=0, idx=0.
REQ-027 rst asserted mid-SETTLE SHALL discard the pending capture; no bit written after rst release.
REQ-028 After rst release, block SHALL remain IDLE until start.

Configuration
REQ-029 Macro TT_CAPTURE_DUP_EN defined: duplicate capture sets err per REQ-022; undefined: duplicates overwrite silently and err is set only by vld overrun (REQ-021).

Verification
REQ-030 SETTLE=2, EXPECTED=16'h8000, start, vld with abcd=0..15 every 4 cycles, f=&abcd -> done=1, table_out=16'h8000, match=1, err=0, busy=0.
REQ-031 Same sweep, f=1 for abcd=5 only -> table_out=16'h0020, match=0, done=1.
REQ-032 Sweep with abcd=3 sent twice (second f=1, first f=0), DUP_EN defined -> table_out[3]=1, err=1; macro undefined -> err=0.
REQ-033 vld pulsed one cycle after an accepted vld (in SETTLE) -> err=1, seen gains only the first pattern.
REQ-034 rst pulse one cycle after vld abcd=7 -> all outputs 0, state IDLE; subsequent vld without start changes nothing.
REQ-035 start asserted on the edge of the 16th capture -> done stays 0, seen=16'h0000, busy=1.
